dcache_controller: RTL and testbench
====================================

Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store stage and the block-granular data memory.
- Serves 32-bit word accesses from the CPU and stalls the pipeline on a miss.
- On a miss it acts as initiator of the memory enable/ack block protocol, doing a dirty-victim writeback first and then a block refill.
- Also keeps hit and miss event counters.

Parameters:
- pBlockSize, 32, block size in bytes; must be 32 (8 words, 256-bit block bus).
- pNumLines, 32, number of cache lines; a power of two.
- pIndexBits, 5, log2(pNumLines).

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- cpu_req_i  in  1  CPU access request this cycle.
- cpu_write_i  in  1  1 = store, 0 = load.
- cpu_addr_i  in  32  byte address; bits [1:0] ignored.
- cpu_wdata_i  in  32  store data.
- cpu_rdata_o  out  32  load data; valid when cpu_req_i=1 and cpu_stall_o=0.
- cpu_stall_o  out  1  CPU must hold the request unchanged while high.
- mem_enable_o  out  1  memory request valid.
- mem_addr_o  out  32  block address (byte address >> 5).
- mem_write_ctrl_o  out  1  1 = write block, 0 = read block.
- mem_write_data_o  out  256  victim block data.
- mem_read_data_i  in  256  refill data; valid in the cycle mem_ack_i=1.
- mem_ack_i  in  1  one-cycle completion pulse from memory.
- hit_count_o  out  32  number of hits accepted.
- miss_count_o  out  32  number of misses detected.

Behaviour:
- Address split:
  - word offset = addr[4:2]
  - index = addr[pIndexBits+4:5]
  - tag = addr[31:pIndexBits+5]
- Per-line storage: valid, dirty, tag, 256-bit data. Word w occupies data bits [32w+31:32w].
- hit = cpu_req_i & valid[index] & (tag[index] == tag). This is combinational.
- cpu_stall_o = cpu_req_i & (state != IDLE | !hit). This is combinational, so a miss stalls in the same cycle.
- Load hit:
  - cpu_rdata_o gives the selected word combinationally; zero-cycle latency.
  - When there is no hit, cpu_rdata_o = 0.
- Store hit:
  - At the posedge, the selected word is written and dirty[index] is set to 1.
  - Other words in the line are unchanged.
- Counters:
  - hit_count_o increments on each posedge with state=IDLE and hit.
  - miss_count_o increments on each IDLE->WRITEBACK or IDLE->ALLOCATE transition.
  - Both wrap modulo 2^32.
  - A request that misses and then hits after refill counts once as a miss and once as a hit.
- FSM states: IDLE, WRITEBACK, GAP, ALLOCATE.
  - IDLE, cpu_req_i and miss:
    - Victim valid and dirty: go to WRITEBACK.
    - Otherwise: go to ALLOCATE.
  - WRITEBACK: drive mem_enable_o=1, mem_write_ctrl_o=1, mem_addr_o={victim tag, index}, mem_write_data_o=victim line. On mem_ack_i go to GAP.
  - GAP: mem_enable_o=0 for exactly one cycle, then go to ALLOCATE.
  - ALLOCATE: drive mem_enable_o=1, mem_write_ctrl_o=0, mem_addr_o=cpu_addr_i[31:5].
    - On mem_ack_i: line data <= mem_read_data_i, valid<=1, dirty<=0, tag<=CPU tag, then go to IDLE.
    - The next cycle re-evaluates as a hit. A pending store completes then and sets dirty.
- Handshake rules:
  - mem_enable_o is Moore (a function of state only).
  - mem_addr_o, mem_write_ctrl_o and mem_write_data_o are held stable from the enable rise until the ack cycle inclusive.
  - mem_enable_o drops on the posedge that samples mem_ack_i=1.
  - Outside WRITEBACK and ALLOCATE: mem_enable_o=0, mem_write_ctrl_o=0, mem_addr_o=0, mem_write_data_o=0.
  - mem_ack_i is ignored in IDLE and GAP.
- Latency, with memory ack L cycles after enable rise:
  - Clean miss: stall for L+2 cycles.
  - Dirty miss: stall for 2L+4 cycles.
- cpu_req_i dropping mid-miss: the transaction still completes and the line is filled. The CPU must not change cpu_addr_i while stalled.
- Reset (synchronous):
  - state=IDLE.
  - All valid and dirty bits cleared.
  - Counters = 0.
  - All mem_* outputs = 0.
  - Line data and tags are not cleared.
  - Reset mid-transaction abandons it. The memory shares rst_i, so the memory also returns to idle.

Test Plan:
- Reset, then load 0x00000404 -> stall high; mem_enable_o rises next cycle with mem_addr_o=0x20, write_ctrl=0. Memory returns word1=0xDEADBEEF -> after ack, stall low and cpu_rdata_o=0xDEADBEEF. miss_count=1, hit_count=1.
- Store 0x11223344 to 0x00000408 (same line) -> no stall, zero mem activity. A following load of 0x408 returns 0x11223344. dirty[0]=1.
- Load 0x00000004 (index 0, tag 0, conflict):
  - WRITEBACK first: mem_addr_o=0x20, write_ctrl=1, word2 of mem_write_data_o=0x11223344.
  - Exactly one cycle with enable low.
  - Then a read of mem_addr_o=0x00.
- Clean conflicting miss -> no writeback; only one read transaction issued. miss_count increments by 1.
- Assert rst_i while in ALLOCATE -> next cycle mem_enable_o=0 and state IDLE. A repeat load of the same address misses again and counters restart from 0.
- Hold mem_ack_i low for 20 cycles in ALLOCATE -> mem_enable_o, mem_addr_o and mem_write_ctrl_o stay constant throughout. A spurious mem_ack_i in IDLE has no effect.

Source files
------------

// File: rtl/dcache_controller.sv
`timescale 1ns / 1ps
// Direct-mapped, write-back, write-allocate data cache with a block-granular memory port.
// Misses stall the CPU while a dirty victim is written back and the line is refilled.
module dcache_controller #(
  parameter int unsigned pBlockSize = 32,
  parameter int unsigned pNumLines  = 32,
  parameter int unsigned pIndexBits = 5
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      cpu_req_i,
  input  logic                      cpu_write_i,
  input  logic [31:0]               cpu_addr_i,
  input  logic [31:0]               cpu_wdata_i,
  output logic [31:0]               cpu_rdata_o,
  output logic                      cpu_stall_o,
  output logic                      mem_enable_o,
  output logic [31:0]               mem_addr_o,
  output logic                      mem_write_ctrl_o,
  output logic [pBlockSize*8-1:0]   mem_write_data_o,
  input  logic [pBlockSize*8-1:0]   mem_read_data_i,
  input  logic                      mem_ack_i,
  output logic [31:0]               hit_count_o,
  output logic [31:0]               miss_count_o
);

  localparam int unsigned BlockBits = pBlockSize * 8;
  localparam int unsigned TagBits   = 32 - pIndexBits - 5;

  typedef enum logic [1:0] {StIdle, StWriteback, StGap, StAllocate} state_e;

  state_e state_q, state_d;

  logic [pNumLines-1:0] valid_q, dirty_q;
  logic [TagBits-1:0]   tag_q  [pNumLines];
  logic [BlockBits-1:0] data_q [pNumLines];
  logic [31:0]          hit_count_q, miss_count_q;

  logic [2:0]            word;
  logic [pIndexBits-1:0] idx;
  logic [TagBits-1:0]    tag;
  logic                  hit, accept_store, refill;
  logic                  unused_addr_bits;

  assign word             = cpu_addr_i[4:2];
  assign idx              = cpu_addr_i[pIndexBits+4:5];
  assign tag              = cpu_addr_i[31:pIndexBits+5];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit          = cpu_req_i & valid_q[idx] & (tag_q[idx] == tag);
  assign cpu_stall_o  = cpu_req_i & ((state_q != StIdle) | ~hit);
  assign cpu_rdata_o  = hit ? data_q[idx][32*word +: 32] : 32'h0;
  assign accept_store = (state_q == StIdle) & hit & cpu_write_i;
  assign refill       = (state_q == StAllocate) & mem_ack_i;

  assign hit_count_o  = hit_count_q;
  assign miss_count_o = miss_count_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req_i && !hit) begin
          state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
        end
      end
      StWriteback: if (mem_ack_i) state_d = StGap;
      StGap:       state_d = StAllocate;
      StAllocate:  if (mem_ack_i) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
  end

  // Request fields come from stored state or the held CPU address, so they stay
  // stable for the whole enable..ack window.
  always_comb begin
    mem_enable_o     = 1'b0;
    mem_write_ctrl_o = 1'b0;
    mem_addr_o       = 32'h0;
    mem_write_data_o = '0;
    unique case (state_q)
      StWriteback: begin
        mem_enable_o     = 1'b1;
        mem_write_ctrl_o = 1'b1;
        mem_addr_o       = 32'({tag_q[idx], idx});
        mem_write_data_o = data_q[idx];
      end
      StAllocate: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {5'b0, cpu_addr_i[31:5]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      valid_q      <= '0;
      dirty_q      <= '0;
      hit_count_q  <= 32'h0;
      miss_count_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (state_q == StIdle && hit) hit_count_q <= hit_count_q + 32'd1;
      if (state_q == StIdle && cpu_req_i && !hit) miss_count_q <= miss_count_q + 32'd1;
      if (accept_store) dirty_q[idx] <= 1'b1;
      if (refill) begin
        valid_q[idx] <= 1'b1;
        dirty_q[idx] <= 1'b0;
      end
    end
  end

  // Line data and tags are not reset; the valid bits guard them.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (refill) begin
        data_q[idx] <= mem_read_data_i;
        tag_q[idx]  <= tag;
      end else if (accept_store) begin
        data_q[idx][32*word +: 32] <= cpu_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
`timescale 1ns / 1ps
// Directed bench for dcache_controller: a table of CPU accesses against a block memory
// responder, plus hand-written sequences for long acks, spurious acks and mid-miss reset.
module tb_dcache_controller;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req = 1'b0, wr = 1'b0;
  logic [31:0]  addr = 32'h0, wdata = 32'h0;
  logic [31:0]  rdata;
  logic         stall;
  logic         mem_en, mem_wctl, mem_ack;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, mem_rdata;
  logic [31:0]  hit_cnt, miss_cnt;

  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .cpu_req_i        (req),
    .cpu_write_i      (wr),
    .cpu_addr_i       (addr),
    .cpu_wdata_i      (wdata),
    .cpu_rdata_o      (rdata),
    .cpu_stall_o      (stall),
    .mem_enable_o     (mem_en),
    .mem_addr_o       (mem_addr),
    .mem_write_ctrl_o (mem_wctl),
    .mem_write_data_o (mem_wdata),
    .mem_read_data_i  (mem_rdata),
    .mem_ack_i        (mem_ack),
    .hit_count_o      (hit_cnt),
    .miss_count_o     (miss_cnt)
  );

  int nvec = 0, nfail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Block memory model: untouched blocks hold A0000000 | block<<4 | word.
  logic [255:0] mem_blk [int];
  int  ack_delay = 1;
  int  rd_txn = 0, wr_txn = 0, stab_err = 0, last_gap = -1;
  bit  spurious = 0;
  logic [31:0] last_rd_addr = 32'h0;

  function automatic logic [255:0] blk_data(input logic [31:0] b);
    logic [255:0] d;
    if (mem_blk.exists(int'(b))) return mem_blk[int'(b)];
    for (int w = 0; w < 8; w++) d[32*w +: 32] = 32'hA000_0000 | (b << 4) | 32'(w);
    return d;
  endfunction

  initial begin
    bit busy = 0, after_wr = 0, t_wr = 0;
    int cnt = 0, gap_cnt = 0;
    logic [31:0]  t_addr = 32'h0;
    logic [255:0] t_data = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack   = 1'b0;
      mem_rdata = '0;
      if (rst) begin
        busy = 0; after_wr = 0;
      end else begin
        if (after_wr) begin
          if (!mem_en) gap_cnt++;
          else begin last_gap = gap_cnt; after_wr = 0; end
        end
        if (mem_en && !busy) begin
          busy = 1; cnt = 0; t_addr = mem_addr; t_wr = mem_wctl; t_data = mem_wdata;
        end
        if (busy) begin
          if (!mem_en || mem_addr !== t_addr || mem_wctl !== t_wr ||
              (t_wr && mem_wdata !== t_data)) stab_err++;
          if (cnt == ack_delay) begin
            mem_ack = 1'b1;
            busy    = 0;
            if (t_wr) begin
              mem_blk[int'(t_addr)] = t_data;
              wr_txn++; after_wr = 1; gap_cnt = 0;
            end else begin
              mem_rdata = blk_data(t_addr);
              rd_txn++; last_rd_addr = t_addr;
            end
          end else cnt++;
        end else if (spurious) begin
          mem_ack = 1'b1; mem_rdata = '1; spurious = 0;
        end
      end
    end
  end

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output int stalls);
    @(negedge clk);
    req = 1'b1; wr = w; addr = a; wdata = d; stalls = 0;
    #1;
    while (stall && stalls < 500) begin
      @(negedge clk); #1;
      stalls++;
    end
    rd = rdata;
    @(posedge clk); #1;
    req = 1'b0; wr = 1'b0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          chk_rd;
    int          exp_stalls;
    int          exp_rd;
    int          exp_wr;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0]  rd;
    logic [255:0] b20;
    int st, rd0, wr0;

    b20 = blk_data(32'h20);
    b20[63:32] = 32'hDEAD_BEEF;
    mem_blk[32'h20] = b20;

    // ack_delay=1: clean miss stalls 3 cycles, dirty miss 6.
    vecs[0]  = '{0, 32'h404, 32'h0,        32'hDEAD_BEEF, 1, 3, 1, 0};
    vecs[1]  = '{1, 32'h408, 32'h1122_3344, 32'h0,        0, 0, 0, 0};
    vecs[2]  = '{0, 32'h408, 32'h0,        32'h1122_3344, 1, 0, 0, 0};
    vecs[3]  = '{0, 32'h404, 32'h0,        32'hDEAD_BEEF, 1, 0, 0, 0};
    vecs[4]  = '{0, 32'h004, 32'h0,        32'hA000_0001, 1, 6, 1, 1};
    vecs[5]  = '{0, 32'h408, 32'h0,        32'h1122_3344, 1, 3, 1, 0};
    vecs[6]  = '{0, 32'h024, 32'h0,        32'hA000_0011, 1, 3, 1, 0};
    vecs[7]  = '{1, 32'h03C, 32'hCAFE_F00D, 32'h0,        0, 0, 0, 0};
    vecs[8]  = '{0, 32'h03C, 32'h0,        32'hCAFE_F00D, 1, 0, 0, 0};
    vecs[9]  = '{1, 32'h7E0, 32'h55AA_55AA, 32'h0,        0, 3, 1, 0};
    vecs[10] = '{0, 32'h7E0, 32'h0,        32'h55AA_55AA, 1, 0, 0, 0};
    vecs[11] = '{0, 32'hFE0, 32'h0,        32'hA000_07F0, 1, 6, 1, 1};
    vecs[12] = '{0, 32'h7E0, 32'h0,        32'h55AA_55AA, 1, 3, 1, 0};

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    check("reset_stall", 32'(stall), 32'h0);
    check("reset_mem_en", 32'(mem_en), 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_hits", hit_cnt, 32'h0);
    check("reset_misses", miss_cnt, 32'h0);

    for (int i = 0; i < 13; i++) begin
      rd0 = rd_txn; wr0 = wr_txn;
      access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, st);
      check($sformatf("v%0d_stalls", i), 32'(st), 32'(vecs[i].exp_stalls));
      if (vecs[i].chk_rd) check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_reads", i), 32'(rd_txn - rd0), 32'(vecs[i].exp_rd));
      check($sformatf("v%0d_writes", i), 32'(wr_txn - wr0), 32'(vecs[i].exp_wr));
    end
    check("table_hits", hit_cnt, 32'd13);
    check("table_misses", miss_cnt, 32'd7);
    check("wb_gap_cycles", 32'(last_gap), 32'd1);
    check("wb_block_20", 32'(mem_blk.exists(32'h20)), 32'd1);
    check("handshake_stable", 32'(stab_err), 32'd0);

    // Long ack: request fields must hold for the full 21-cycle enable window.
    ack_delay = 20;
    access(0, 32'h1000, 32'h0, rd, st);
    check("slow_stalls", 32'(st), 32'd22);
    check("slow_rdata", rd, 32'hA000_0800);
    check("slow_rd_addr", last_rd_addr, 32'h80);
    check("slow_stable", 32'(stab_err), 32'd0);

    // Spurious ack while idle must not disturb the cache.
    @(negedge clk); spurious = 1;
    repeat (3) @(negedge clk);
    check("spur_mem_en", 32'(mem_en), 32'h0);
    check("spur_hits", hit_cnt, 32'd14);
    check("spur_misses", miss_cnt, 32'd8);
    access(0, 32'h1000, 32'h0, rd, st);
    check("spur_hit_stalls", 32'(st), 32'd0);
    check("spur_hit_rdata", rd, 32'hA000_0800);

    // Reset during a refill abandons it and clears valid bits and counters.
    @(negedge clk); req = 1'b1; wr = 1'b0; addr = 32'h2000;
    repeat (4) @(negedge clk);
    check("alloc_mem_en", 32'(mem_en), 32'h1);
    check("alloc_mem_addr", mem_addr, 32'h100);
    check("alloc_wctl", 32'(mem_wctl), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mem_en", 32'(mem_en), 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_misses", miss_cnt, 32'h0);
    @(negedge clk); rst = 1'b0; req = 1'b0;
    ack_delay = 1;
    access(0, 32'h2000, 32'h0, rd, st);
    check("post_rst_stalls", 32'(st), 32'd3);
    check("post_rst_rdata", rd, 32'hA000_1000);
    check("post_rst_hits", hit_cnt, 32'd1);
    check("post_rst_misses", miss_cnt, 32'd1);
    access(0, 32'h1000, 32'h0, rd, st);
    check("post_rst_refetch", 32'(st), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
